// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow_out
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one full-subtractor step
// per clock, LSB first, with the borrow held in a flip-flop between bits.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sa_next;

  // sa doubles as the result shift register: each consumed minuend bit frees
  // the top slot for a difference bit, so after WIDTH steps sa holds the result.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sa_next = (sa >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of sa/sb/br, exactly like parallel flip-flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sa             <= '0;
      sb             <= '0;
      br             <= 1'b0;
      cnt            <= '0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sa           <= bus.a;
            sb           <= bus.b;
            br           <= bus.bin;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa_next;
          sb  <= sb >> 1;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.out_valid  <= 1'b1;
            bus.diff       <= sa_next;
            bus.borrow_out <= br_next;
            state          <= DONE;
          end
        end
        DONE: begin
          // diff/borrow_out are left untouched so they persist after the handoff.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances
// compared against an arithmetic reference ({0,a}-{0,b}-bin).
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - 9'(bin);
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic bin);
    return {1'b0, a} - {1'b0, b} - 2'(bin);
  endfunction

  // Accept one operand set on dut8 and wait for the result; leaves it in DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    logic [8:0] exp;
    int cyc;
    exp = model8(a, b, bin);
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.in_valid = 1'b1;
    n_checks++;
    if (bus8.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready before accept: got %b want 1", tag, bus8.in_ready);
    end
    tick();
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    cyc = 0;
    while (bus8.out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 8) begin
      n_fail++; $display("FAIL %s latency: got %0d want 8", tag, cyc);
    end
    n_checks++;
    if (bus8.diff !== exp[7:0]) begin
      n_fail++; $display("FAIL %s diff: got %h want %h", tag, bus8.diff, exp[7:0]);
    end
    n_checks++;
    if (bus8.borrow_out !== exp[8]) begin
      n_fail++; $display("FAIL %s borrow_out: got %b want %b", tag, bus8.borrow_out, exp[8]);
    end
  endtask

  task automatic release8(input string tag);
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1",
                         tag, bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset8 handshake: got in_ready=%b out_valid=%b want 1/0",
                         bus8.in_ready, bus8.out_valid);
    end
    n_checks++;
    if (bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL reset8 result: got diff=%h borrow=%b want 00/0", bus8.diff, bus8.borrow_out);
    end
    n_checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.diff !== 1'b0 || bus1.borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL reset1: got in_ready=%b out_valid=%b diff=%b borrow=%b want 1/0/0/0",
                         bus1.in_ready, bus1.out_valid, bus1.diff, bus1.borrow_out);
    end
  endtask

  task automatic test_directed();
    op8(8'd5,   8'd3,   1'b0, "5-3");     release8("5-3");
    op8(8'd3,   8'd5,   1'b0, "3-5");     release8("3-5");
    op8(8'd0,   8'd0,   1'b1, "0-0-1");   release8("0-0-1");
    op8(8'hFF,  8'hFF,  1'b1, "FF-FF-1"); release8("FF-FF-1");
    op8(8'h00,  8'hFF,  1'b0, "00-FF");   release8("00-FF");
    op8(8'hFF,  8'h00,  1'b1, "FF-00-1"); release8("FF-00-1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic       rbin;
      logic [8:0] exp;
      int         hold;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 4 == 0) rb = ra;
      exp = model8(ra, rb, rbin);
      op8(ra, rb, rbin, "rand");
      hold = int'($urandom_range(3, 0));
      for (int k = 0; k < hold; k++) tick();
      n_checks++;
      if (bus8.out_valid !== 1'b1 || {bus8.borrow_out, bus8.diff} !== exp) begin
        n_fail++; $display("FAIL rand hold: got valid=%b {b,d}=%h want 1/%h",
                           bus8.out_valid, {bus8.borrow_out, bus8.diff}, exp);
      end
      release8("rand");
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp;
    int bad;
    exp = model8(8'h21, 8'h47, 1'b1);
    op8(8'h21, 8'h47, 1'b1, "bp");
    bus8.in_valid = 1'b1; bus8.a = 8'h99; bus8.b = 8'h11; bus8.bin = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 ||
          {bus8.borrow_out, bus8.diff} !== exp) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp hold: got %0d bad cycles want 0 (last {b,d}=%h want %h in_ready=%b)",
                         bad, {bus8.borrow_out, bus8.diff}, exp, bus8.in_ready);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp release: got in_ready=%b out_valid=%b want 1/0", bus8.in_ready, bus8.out_valid);
    end
    n_checks++;
    if ({bus8.borrow_out, bus8.diff} !== exp) begin
      n_fail++; $display("FAIL bp keep: got %h want %h", {bus8.borrow_out, bus8.diff}, exp);
    end
    tick();
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp no-capture: got in_ready=%b out_valid=%b want 1/0", bus8.in_ready, bus8.out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    bus8.a = 8'hC3; bus8.b = 8'h5A; bus8.bin = 1'b1; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.diff !== 8'h00 || bus8.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort shift: got valid=%b diff=%h in_ready=%b want 0/00/1",
                         bus8.out_valid, bus8.diff, bus8.in_ready);
    end
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus8.out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort residue: got %0d valid cycles want 0", bad);
    end
    op8(8'd9, 8'd3, 1'b0, "9-3");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0 || bus8.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort done: got valid=%b diff=%h borrow=%b in_ready=%b want 0/00/0/1",
                         bus8.out_valid, bus8.diff, bus8.borrow_out, bus8.in_ready);
    end
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp;
      v   = 3'(i);
      exp = model1(v[2], v[1], v[0]);
      bus1.a = v[2]; bus1.b = v[1]; bus1.bin = v[0]; bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      tick();
      n_checks++;
      if (bus1.out_valid !== 1'b1 || {bus1.borrow_out, bus1.diff} !== exp) begin
        n_fail++; $display("FAIL w1 abc=%b: got valid=%b {b,d}=%b want 1/%b",
                           v, bus1.out_valid, {bus1.borrow_out, bus1.diff}, exp);
      end
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
